// File: rtl/b_74138_scan_ctrl_if.sv
// Bus bundle for the 74138 scan sequencer: scan control inputs from the
// host side and the decoder-facing select/enable outputs.
// Optional macro SCAN_CTRL_DESC_EN adds the dir_i scan-direction input.
interface b_74138_scan_ctrl_if #(
   parameter int DWELL_W = 8
);
   logic               start_i;
   logic               stop_i;
   logic               oneshot_i;
   logic [7:0]         mask_i;
   logic [DWELL_W-1:0] dwell_i;
`ifdef SCAN_CTRL_DESC_EN
   logic               dir_i;
`endif
   logic               select_a_o;
   logic               select_b_o;
   logic               select_c_o;
   logic               g1_en_o;
   logic               g2a_en_n_o;
   logic               g2b_en_n_o;
   logic [2:0]         chan_o;
   logic               busy_o;
   logic               done_o;

   // Host side: issues scan commands, observes decoder pins and status.
   modport master (
`ifdef SCAN_CTRL_DESC_EN
      output dir_i,
`endif
      output start_i, stop_i, oneshot_i, mask_i, dwell_i,
      input  select_a_o, select_b_o, select_c_o,
      input  g1_en_o, g2a_en_n_o, g2b_en_n_o,
      input  chan_o, busy_o, done_o
   );

   // Sequencer side.
   modport slave (
`ifdef SCAN_CTRL_DESC_EN
      input  dir_i,
`endif
      input  start_i, stop_i, oneshot_i, mask_i, dwell_i,
      output select_a_o, select_b_o, select_c_o,
      output g1_en_o, g2a_en_n_o, g2b_en_n_o,
      output chan_o, busy_o, done_o
   );
endinterface

// File: rtl/b_74138_scan_ctrl.sv
// Registered scan sequencer for a 74138 3-to-8 decoder. Steps through the
// channels enabled in a mask, inserting BLANK_CYCLES of disabled enables
// before each channel's dwell so selects never move while enabled.
// Optional macro SCAN_CTRL_DESC_EN: adds dir_i for descending scans.
module b_74138_scan_ctrl #(
   parameter int DWELL_W      = 8,
   parameter int BLANK_CYCLES = 1   // legal range 1..15
) (
   input logic                 clk_i,
   input logic                 rst_n_i,
   b_74138_scan_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_DWELL = 2'd2
   } state_t;

   localparam logic [3:0] BLANK_LOAD = 4'(BLANK_CYCLES - 1);

   state_t             state_q, state_d;
   logic [2:0]         chan_q, chan_d;
   logic [7:0]         mask_q, mask_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic               oneshot_q, oneshot_d;
   logic [3:0]         blank_cnt_q, blank_cnt_d;
   logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
   logic               g1_en_q, g1_en_d;
   logic               g2_en_n_q, g2_en_n_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   // Channel-ordering helpers
   logic [2:0] first_asc, next_asc;
   logic [2:0] first_chan, next_chan;
   logic       pass_done;

   // Ascending order: lowest set bit of the incoming mask, and the next set
   // bit above the current channel (wrapping 7->0; offset 8 lands on itself).
   always_comb begin
      first_asc = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (bus.mask_i[i]) first_asc = 3'(i);
      end
      next_asc = chan_q;
      for (int i = 8; i >= 1; i--) begin
         if (mask_q[chan_q + 3'(i)]) next_asc = chan_q + 3'(i);
      end
   end

`ifdef SCAN_CTRL_DESC_EN
   logic       dir_q, dir_d;
   logic [2:0] first_desc, next_desc;

   // Descending order: highest set bit first, next set bit below (0->7 wrap).
   always_comb begin
      first_desc = 3'd0;
      for (int i = 0; i <= 7; i++) begin
         if (bus.mask_i[i]) first_desc = 3'(i);
      end
      next_desc = chan_q;
      for (int i = 8; i >= 1; i--) begin
         if (mask_q[chan_q - 3'(i)]) next_desc = chan_q - 3'(i);
      end
   end

   // Direction select: a pass ends when the order wraps or repeats.
   always_comb begin
      dir_d      = dir_q;
      first_chan = bus.dir_i ? first_desc : first_asc;
      next_chan  = dir_q ? next_desc : next_asc;
      pass_done  = dir_q ? (next_desc >= chan_q) : (next_asc <= chan_q);
      if (state_q == ST_IDLE && bus.start_i && !bus.stop_i && bus.mask_i != 8'd0)
         dir_d = bus.dir_i;
   end

   // Latched scan direction.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) dir_q <= 1'b0;
      else          dir_q <= dir_d;
   end
`else
   // Ascending-only build.
   always_comb begin
      first_chan = first_asc;
      next_chan  = next_asc;
      pass_done  = (next_asc <= chan_q);
   end
`endif

   // Next-state logic; stop_i overrides everything, output flops follow state_d.
   always_comb begin
      state_d     = state_q;
      chan_d      = chan_q;
      mask_d      = mask_q;
      dwell_d     = dwell_q;
      oneshot_d   = oneshot_q;
      blank_cnt_d = blank_cnt_q;
      dwell_cnt_d = dwell_cnt_q;
      done_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            chan_d = 3'd0;
            if (bus.start_i && bus.mask_i != 8'd0) begin
               state_d     = ST_BLANK;
               chan_d      = first_chan;
               mask_d      = bus.mask_i;
               dwell_d     = bus.dwell_i;
               oneshot_d   = bus.oneshot_i;
               blank_cnt_d = BLANK_LOAD;
            end
         end
         ST_BLANK: begin
            if (blank_cnt_q == 4'd0) begin
               state_d     = ST_DWELL;
               // A dwell of 0 behaves as a single enabled cycle.
               dwell_cnt_d = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
            end else begin
               blank_cnt_d = blank_cnt_q - 4'd1;
            end
         end
         ST_DWELL: begin
            if (dwell_cnt_q == '0) begin
               if (pass_done && oneshot_q) begin
                  state_d = ST_IDLE;
                  chan_d  = 3'd0;
                  done_d  = 1'b1;
               end else begin
                  state_d     = ST_BLANK;
                  chan_d      = next_chan;
                  blank_cnt_d = BLANK_LOAD;
               end
            end else begin
               dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            chan_d  = 3'd0;
         end
      endcase

      if (bus.stop_i) begin
         state_d = ST_IDLE;
         chan_d  = 3'd0;
         done_d  = 1'b0;
      end

      g1_en_d   = (state_d == ST_DWELL);
      g2_en_n_d = (state_d != ST_DWELL);
      busy_d    = (state_d != ST_IDLE);
   end

   // State, latched parameters, counters and registered outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= ST_IDLE;
         chan_q      <= 3'd0;
         mask_q      <= 8'd0;
         dwell_q     <= '0;
         oneshot_q   <= 1'b0;
         blank_cnt_q <= 4'd0;
         dwell_cnt_q <= '0;
         g1_en_q     <= 1'b0;
         g2_en_n_q   <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         chan_q      <= chan_d;
         mask_q      <= mask_d;
         dwell_q     <= dwell_d;
         oneshot_q   <= oneshot_d;
         blank_cnt_q <= blank_cnt_d;
         dwell_cnt_q <= dwell_cnt_d;
         g1_en_q     <= g1_en_d;
         g2_en_n_q   <= g2_en_n_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.select_a_o = chan_q[0];
   assign bus.select_b_o = chan_q[1];
   assign bus.select_c_o = chan_q[2];
   assign bus.chan_o     = chan_q;
   assign bus.g1_en_o    = g1_en_q;
   assign bus.g2a_en_n_o = g2_en_n_q;
   assign bus.g2b_en_n_o = g2_en_n_q;
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;

endmodule

// File: tb/tb_b_74138_scan_ctrl.sv
// Scoreboard bench for b_74138_scan_ctrl: the driver expands each scan
// command into the expected per-cycle pin sequence and queues it; a monitor
// on the falling edge pops and compares against the DUT pins.
module tb_b_74138_scan_ctrl;
   localparam int DW = 8;
   localparam int BL = 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   b_74138_scan_ctrl_if #(.DWELL_W(DW)) bus ();

   b_74138_scan_ctrl #(.DWELL_W(DW), .BLANK_CYCLES(BL)) dut (
      .clk_i  (clk),
      .rst_n_i(rst_n),
      .bus    (bus.slave)
   );

   typedef struct packed {
      logic [2:0] sel;
      logic [2:0] chan;
      logic       g1;
      logic       g2a_n;
      logic       g2b_n;
      logic       busy;
      logic       done;
   } rec_t;

   rec_t  exp_q[$];
   rec_t  seq[$];
   int    n_checks = 0;
   int    n_pass = 0;
   string phase = "init";
   bit    cur_dir = 1'b0;

   function automatic rec_t mk(int c, bit active, bit busy, bit done);
      rec_t r;
      r.sel   = 3'(c);
      r.chan  = 3'(c);
      r.g1    = active;
      r.g2a_n = !active;
      r.g2b_n = !active;
      r.busy  = busy;
      r.done  = done;
      return r;
   endfunction

   function automatic rec_t sample();
      rec_t r;
      r.sel   = {bus.select_c_o, bus.select_b_o, bus.select_a_o};
      r.chan  = bus.chan_o;
      r.g1    = bus.g1_en_o;
      r.g2a_n = bus.g2a_en_n_o;
      r.g2b_n = bus.g2b_en_n_o;
      r.busy  = bus.busy_o;
      r.done  = bus.done_o;
      return r;
   endfunction

   task automatic check(string name, rec_t act, rec_t exp);
      n_checks++;
      if (act === exp) n_pass++;
      else
         $display("FAIL %s: got sel=%0d chan=%0d g1=%b g2a_n=%b g2b_n=%b busy=%b done=%b, want sel=%0d chan=%0d g1=%b g2a_n=%b g2b_n=%b busy=%b done=%b",
                  name, act.sel, act.chan, act.g1, act.g2a_n, act.g2b_n, act.busy, act.done,
                  exp.sel, exp.chan, exp.g1, exp.g2a_n, exp.g2b_n, exp.busy, exp.done);
   endtask

   // Monitor: one expected record per cycle while the scoreboard holds any.
   always @(negedge clk) begin
      rec_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check(phase, sample(), e);
      end
   end

   // Reference model: ordered channel list, then BL blank + D active cycles each.
   task automatic build(logic [7:0] mask, int dwell, bit oneshot, int passes);
      int ch[$];
      int d;
      seq.delete();
      for (int k = 0; k < 8; k++) if (mask[k]) ch.push_back(k);
      if (cur_dir) ch.reverse();
      d = (dwell == 0) ? 1 : dwell;
      for (int p = 0; p < passes; p++) begin
         foreach (ch[j]) begin
            repeat (BL) seq.push_back(mk(ch[j], 1'b0, 1'b1, 1'b0));
            repeat (d)  seq.push_back(mk(ch[j], 1'b1, 1'b1, 1'b0));
         end
      end
      if (oneshot) begin
         seq.push_back(mk(0, 1'b0, 1'b0, 1'b1));
         seq.push_back(mk(0, 1'b0, 1'b0, 1'b0));
         seq.push_back(mk(0, 1'b0, 1'b0, 1'b0));
      end
   endtask

   task automatic push_range(int a, int b);
      for (int i = a; i <= b; i++) exp_q.push_back(seq[i]);
   endtask

   task automatic push_idle(int n);
      repeat (n) exp_q.push_back(mk(0, 1'b0, 1'b0, 1'b0));
   endtask

   // Returns at negedge+1 once the monitor has consumed every queued record.
   task automatic wait_drain();
      int n = 0;
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (exp_q.size() != 0 && n < 3000);
      if (exp_q.size() != 0) begin
         n_checks++;
         $display("FAIL drain %s: %0d records still pending, want 0", phase, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic drive(logic [7:0] mask, int dwell, bit oneshot, bit start, bit stop);
      bus.mask_i    = mask;
      bus.dwell_i   = DW'(dwell);
      bus.oneshot_i = oneshot;
      bus.start_i   = start;
      bus.stop_i    = stop;
`ifdef SCAN_CTRL_DESC_EN
      bus.dir_i     = cur_dir;
`endif
   endtask

   // Drop start/stop after the sampling edge and scramble the other inputs.
   task automatic release_cmd();
      @(posedge clk);
      #1;
      bus.start_i   = 1'b0;
      bus.stop_i    = 1'b0;
      bus.mask_i    = 8'($urandom);
      bus.dwell_i   = DW'($urandom);
      bus.oneshot_i = 1'($urandom);
`ifdef SCAN_CTRL_DESC_EN
      bus.dir_i     = 1'($urandom);
`endif
   endtask

   task automatic run_oneshot(logic [7:0] mask, int dwell);
      wait_drain();
      build(mask, dwell, 1'b1, 1);
      drive(mask, dwell, 1'b1, 1'b1, 1'b0);
      push_range(0, seq.size() - 1);
      release_cmd();
   endtask

   // Continuous scan cut after record 'cut', then stop_i.
   task automatic run_cont_stop(logic [7:0] mask, int dwell, int passes, int cut_sel);
      int cut;
      wait_drain();
      build(mask, dwell, 1'b0, passes);
      cut = (cut_sel < 0 || cut_sel >= seq.size()) ? seq.size() - 1 : cut_sel;
      drive(mask, dwell, 1'b0, 1'b1, 1'b0);
      push_range(0, cut);
      release_cmd();
      wait_drain();
      bus.stop_i = 1'b1;
      push_idle(2);
      @(posedge clk);
      #1;
      bus.stop_i = 1'b0;
   endtask

   initial begin
      int idx;
      logic [7:0] m;
      int d;
      bit os;
      drive(8'h00, 0, 1'b0, 1'b0, 1'b0);
      #12;
      phase = "reset_values";
      check(phase, sample(), mk(0, 1'b0, 1'b0, 1'b0));
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      push_idle(2);

      phase = "ff_oneshot";
      $display("scan %s mask=ff dwell=2 oneshot=1", phase);
      run_oneshot(8'hFF, 2);

      phase = "a4_cont_dwell0";
      $display("scan %s mask=a4 dwell=0 oneshot=0", phase);
      run_cont_stop(8'b1010_0100, 0, 3, -1);

      phase = "mask_zero";
      $display("scan %s mask=00 start", phase);
      wait_drain();
      drive(8'h00, 3, 1'b1, 1'b1, 1'b0);
      push_idle(3);
      release_cmd();

      phase = "stop_mid_dwell_ch3";
      m = 8'($urandom) | 8'h08;
      $display("scan %s mask=%h dwell=3 oneshot=0", phase, m);
      build(m, 3, 1'b0, 2);
      idx = 0;
      for (int i = seq.size() - 1; i >= seq.size() / 2; i--)
         if (seq[i].g1 && seq[i].chan == 3'd3) idx = i;
      run_cont_stop(m, 3, 2, idx + 1);

      phase = "start_and_stop_idle";
      $display("scan %s mask=ff start+stop", phase);
      wait_drain();
      drive(8'hFF, 1, 1'b1, 1'b1, 1'b1);
      push_idle(3);
      release_cmd();

      phase = "start_pulse_mid_scan";
      m = 8'($urandom_range(1, 255));
      $display("scan %s mask=%h dwell=1 oneshot=1", phase, m);
      wait_drain();
      build(m, 1, 1'b1, 1);
      idx = seq.size() / 2;
      drive(m, 1, 1'b1, 1'b1, 1'b0);
      push_range(0, idx);
      release_cmd();
      wait_drain();
      drive(8'($urandom_range(1, 255)), 5, 1'b0, 1'b1, 1'b0);
      push_range(idx + 1, seq.size() - 1);
      release_cmd();

      phase = "async_reset";
      m = 8'($urandom_range(1, 255));
      $display("scan %s mask=%h dwell=3 oneshot=1", phase, m);
      wait_drain();
      build(m, 3, 1'b1, 1);
      idx = 0;
      for (int i = seq.size() - 1; i >= 0; i--) if (seq[i].g1) idx = i;
      drive(m, 3, 1'b1, 1'b1, 1'b0);
      push_range(0, idx + 1);
      release_cmd();
      wait_drain();
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_immediate", sample(), mk(0, 1'b0, 1'b0, 1'b0));
      push_idle(2);
      wait_drain();
      rst_n = 1'b1;
      push_idle(2);

      for (int t = 0; t < 8; t++) begin
         m  = 8'($urandom_range(1, 255));
         d  = int'($urandom_range(0, 3));
         os = 1'($urandom);
`ifdef SCAN_CTRL_DESC_EN
         cur_dir = 1'($urandom);
`endif
         phase = $sformatf("random_%0d", t);
         $display("scan %s mask=%h dwell=%0d oneshot=%0d dir=%0d", phase, m, d, os, cur_dir);
         if (os) run_oneshot(m, d);
         else begin
            build(m, d, 1'b0, 2);
            run_cont_stop(m, d, 2, int'($urandom_range(seq.size() / 2, seq.size() - 1)));
         end
      end
      cur_dir = 1'b0;

`ifdef SCAN_CTRL_DESC_EN
      phase = "desc_81_oneshot";
      cur_dir = 1'b1;
      $display("scan %s mask=81 dwell=1 oneshot=1 dir=1", phase);
      run_oneshot(8'h81, 1);
      cur_dir = 1'b0;
`endif

      wait_drain();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end
endmodule
